// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port-2 arbiter: request tags and parameter ranges.
package vram_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned STAT_W = 16;

    localparam int unsigned RD_LATENCY_MIN   = 1;
    localparam int unsigned RD_LATENCY_MAX   = 4;
    localparam int unsigned DMA_MAX_WAIT_MIN = 2;
    localparam int unsigned DMA_MAX_WAIT_MAX = 255;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_SPR  = 2'd2,
        TAG_DMA  = 2'd3
    } tag_t;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester and memory-port bundle for vram_port_arbiter; slave = arbiter side, master = requesters/memory.
interface vram_port_arbiter_if;
    import vram_arb_pkg::*;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              spr_req;
    logic [ADDR_W-1:0] spr_addr;
    logic              spr_gnt;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_gnt;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] rd_data;
    logic              vid_valid;
    logic              spr_valid;
    logic              dma_valid;
    logic [STAT_W-1:0] stat_spr_stalls;
    logic [STAT_W-1:0] stat_dma_stalls;

    modport slave (
        input  vid_req, vid_addr, spr_req, spr_addr, dma_req, dma_addr, mem_din,
        output spr_gnt, dma_gnt, mem_en, mem_addr, rd_data,
               vid_valid, spr_valid, dma_valid, stat_spr_stalls, stat_dma_stalls
    );

    modport master (
        output vid_req, vid_addr, spr_req, spr_addr, dma_req, dma_addr, mem_din,
        input  spr_gnt, dma_gnt, mem_en, mem_addr, rd_data,
               vid_valid, spr_valid, dma_valid, stat_spr_stalls, stat_dma_stalls
    );

endinterface

// File: rtl/vram_tag_pipe.sv
// Tag shift register matching the memory read latency; last stage decodes to one-hot valids.
module vram_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output logic vid_valid,
    output logic spr_valid,
    output logic dma_valid
);

    tag_t tag_q [DEPTH];
    tag_t tag_d [DEPTH];

    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Async clear drops anything in flight so no stale valid follows a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign vid_valid = (tag_q[DEPTH-1] == TAG_VID);
    assign spr_valid = (tag_q[DEPTH-1] == TAG_SPR);
    assign dma_valid = (tag_q[DEPTH-1] == TAG_DMA);

endmodule

// File: rtl/vram_port_arbiter.sv
// Read-port arbiter: video > starved DMA > sprite > DMA, tagged data return after RD_LATENCY.
// Optional stall counters built when VRAM_ARB_STATS_EN is defined.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned DMA_MAX_WAIT = 8
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    vram_port_arbiter_if.slave   bus
);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("vram_port_arbiter: RD_LATENCY out of range");
    end
    if (DMA_MAX_WAIT < DMA_MAX_WAIT_MIN || DMA_MAX_WAIT > DMA_MAX_WAIT_MAX) begin : g_bad_wait
        $error("vram_port_arbiter: DMA_MAX_WAIT out of range");
    end

    tag_t              grant_tag_c;
    logic              spr_gnt_c;
    logic              dma_gnt_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              dma_starved_c;
    logic [WAIT_W-1:0] dma_wait_q;
    logic [WAIT_W-1:0] dma_wait_d;

    assign dma_starved_c = (dma_wait_q == WAIT_W'(DMA_MAX_WAIT));

    // Fixed-priority grant; a starved DMA jumps ahead of sprite but never video.
    always_comb begin
        grant_tag_c = TAG_NONE;
        spr_gnt_c   = 1'b0;
        dma_gnt_c   = 1'b0;
        mem_addr_c  = '0;
        if (bus.vid_req) begin
            grant_tag_c = TAG_VID;
            mem_addr_c  = bus.vid_addr;
        end else if (bus.dma_req && dma_starved_c) begin
            grant_tag_c = TAG_DMA;
            dma_gnt_c   = 1'b1;
            mem_addr_c  = bus.dma_addr;
        end else if (bus.spr_req) begin
            grant_tag_c = TAG_SPR;
            spr_gnt_c   = 1'b1;
            mem_addr_c  = bus.spr_addr;
        end else if (bus.dma_req) begin
            grant_tag_c = TAG_DMA;
            dma_gnt_c   = 1'b1;
            mem_addr_c  = bus.dma_addr;
        end
    end

    assign bus.spr_gnt  = spr_gnt_c;
    assign bus.dma_gnt  = dma_gnt_c;
    assign bus.mem_en   = (grant_tag_c != TAG_NONE);
    assign bus.mem_addr = mem_addr_c;
    assign bus.rd_data  = bus.mem_din;

    always_comb begin
        dma_wait_d = dma_wait_q;
        if (!bus.dma_req || dma_gnt_c) begin
            dma_wait_d = '0;
        end else if (!dma_starved_c) begin
            dma_wait_d = dma_wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            dma_wait_q <= '0;
        end else begin
            dma_wait_q <= dma_wait_d;
        end
    end

    vram_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk_pixel),
        .rst       (reset),
        .tag_in    (grant_tag_c),
        .vid_valid (bus.vid_valid),
        .spr_valid (bus.spr_valid),
        .dma_valid (bus.dma_valid)
    );

`ifdef VRAM_ARB_STATS_EN
    logic [STAT_W-1:0] spr_stalls_q;
    logic [STAT_W-1:0] spr_stalls_d;
    logic [STAT_W-1:0] dma_stalls_q;
    logic [STAT_W-1:0] dma_stalls_d;

    // Saturating stall counters, cleared only by reset.
    always_comb begin
        spr_stalls_d = spr_stalls_q;
        dma_stalls_d = dma_stalls_q;
        if (bus.spr_req && !spr_gnt_c && (spr_stalls_q != '1)) begin
            spr_stalls_d = spr_stalls_q + STAT_W'(1);
        end
        if (bus.dma_req && !dma_gnt_c && (dma_stalls_q != '1)) begin
            dma_stalls_d = dma_stalls_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            spr_stalls_q <= '0;
            dma_stalls_q <= '0;
        end else begin
            spr_stalls_q <= spr_stalls_d;
            dma_stalls_q <= dma_stalls_d;
        end
    end

    assign bus.stat_spr_stalls = spr_stalls_q;
    assign bus.stat_dma_stalls = dma_stalls_q;
`else
    assign bus.stat_spr_stalls = '0;
    assign bus.stat_dma_stalls = '0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: one instance at RD_LATENCY=1 and one at RD_LATENCY=3 share stimulus.
module tb_vram_port_arbiter;
    import vram_arb_pkg::*;

`ifdef VRAM_ARB_STATS_EN
    localparam int unsigned EXP_SPR_STALLS = 5;
`else
    localparam int unsigned EXP_SPR_STALLS = 0;
`endif

    logic clk_pixel = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_pixel = ~clk_pixel;

    vram_port_arbiter_if if1 ();
    vram_port_arbiter_if if3 ();

    vram_port_arbiter #(.RD_LATENCY(1), .DMA_MAX_WAIT(8)) u_dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (if1.slave)
    );

    vram_port_arbiter #(.RD_LATENCY(3), .DMA_MAX_WAIT(8)) u_dut3 (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (if3.slave)
    );

    assign if3.vid_req  = if1.vid_req;
    assign if3.vid_addr = if1.vid_addr;
    assign if3.spr_req  = if1.spr_req;
    assign if3.spr_addr = if1.spr_addr;
    assign if3.dma_req  = if1.dma_req;
    assign if3.dma_addr = if1.dma_addr;

    function automatic logic [7:0] mdata(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    // Memory model: data is a fixed function of the address, delayed by each instance's latency.
    logic [7:0] mem1_q;
    logic [7:0] mem3_q [3];
    always @(posedge clk_pixel) begin
        mem1_q    <= mdata(if1.mem_addr);
        mem3_q[0] <= mdata(if3.mem_addr);
        mem3_q[1] <= mem3_q[0];
        mem3_q[2] <= mem3_q[1];
    end
    assign if1.mem_din = mem1_q;
    assign if3.mem_din = mem3_q[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic vr, input logic [15:0] va, input logic sr, input logic [15:0] sa,
                         input logic dr, input logic [15:0] da);
        if1.vid_req  = vr;
        if1.vid_addr = va;
        if1.spr_req  = sr;
        if1.spr_addr = sa;
        if1.dma_req  = dr;
        if1.dma_addr = da;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_pixel);
            drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        repeat (2) @(negedge clk_pixel);
        #1;
        check("rst_mem_en",   32'(if1.mem_en), 32'd0);
        check("rst_mem_addr", 32'(if1.mem_addr), 32'd0);
        check("rst_gnts",     32'({if1.spr_gnt, if1.dma_gnt}), 32'd0);
        check("rst_valids1",  32'({if1.vid_valid, if1.spr_valid, if1.dma_valid}), 32'd0);
        check("rst_valids3",  32'({if3.vid_valid, if3.spr_valid, if3.dma_valid}), 32'd0);
        check("rst_stats",    32'({if1.stat_spr_stalls, if1.stat_dma_stalls}), 32'd0);
        @(negedge clk_pixel);
        reset = 1'b0;

        // Video only, addresses 0x0100..0x0103.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pixel);
            drive(i < 4, 16'(16'h0100 + i), 1'b0, 16'h0, 1'b0, 16'h0);
            #1;
            check("vid_mem_en",   32'(if1.mem_en), (i < 4) ? 32'd1 : 32'd0);
            check("vid_mem_addr", 32'(if1.mem_addr), (i < 4) ? 32'(16'h0100 + i) : 32'd0);
            if (i >= 1) begin
                check("vid_valid1", 32'(if1.vid_valid), 32'd1);
                check("vid_data1",  32'(if1.rd_data), 32'(mdata(16'(16'h0100 + i - 1))));
            end
            check("vid_valid3", 32'(if3.vid_valid), (i >= 3) ? 32'd1 : 32'd0);
            if (i >= 3) check("vid_data3", 32'(if3.rd_data), 32'(mdata(16'(16'h0100 + i - 3))));
        end
        idle(4);
        #1;
        check("vid_drained", 32'({if1.vid_valid, if3.vid_valid}), 32'd0);

        // All three request together, then drop one at a time after each grant.
        @(negedge clk_pixel);
        drive(1'b1, 16'h0010, 1'b1, 16'h2000, 1'b1, 16'h4000);
        #1;
        check("vsd0_addr", 32'(if1.mem_addr), 32'h0010);
        check("vsd0_gnts", 32'({if1.spr_gnt, if1.dma_gnt}), 32'd0);
        @(negedge clk_pixel);
        drive(1'b0, 16'h0, 1'b1, 16'h2000, 1'b1, 16'h4000);
        #1;
        check("vsd1_spr_gnt", 32'({if1.spr_gnt, if1.dma_gnt}), 32'b10);
        check("vsd1_addr",    32'(if1.mem_addr), 32'h2000);
        check("vsd1_vvalid",  32'({if1.vid_valid, if1.rd_data}), 32'({1'b1, mdata(16'h0010)}));
        @(negedge clk_pixel);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h4000);
        #1;
        check("vsd2_dma_gnt", 32'({if1.spr_gnt, if1.dma_gnt}), 32'b01);
        check("vsd2_addr",    32'(if1.mem_addr), 32'h4000);
        check("vsd2_svalid",  32'({if1.spr_valid, if1.rd_data}), 32'({1'b1, mdata(16'h2000)}));
        @(negedge clk_pixel);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        #1;
        check("vsd3_dvalid1", 32'({if1.dma_valid, if1.rd_data}), 32'({1'b1, mdata(16'h4000)}));
        check("vsd3_valids3", 32'({if3.vid_valid, if3.spr_valid, if3.dma_valid, if3.rd_data}),
              32'({3'b100, mdata(16'h0010)}));
        @(negedge clk_pixel);
        #1;
        check("vsd4_valids3", 32'({if3.vid_valid, if3.spr_valid, if3.dma_valid, if3.rd_data}),
              32'({3'b010, mdata(16'h2000)}));
        @(negedge clk_pixel);
        #1;
        check("vsd5_valids3", 32'({if3.vid_valid, if3.spr_valid, if3.dma_valid, if3.rd_data}),
              32'({3'b001, mdata(16'h4000)}));
        idle(3);

        // Sprite and DMA held: DMA wins on the 9th and 18th cycles.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_pixel);
            drive(1'b0, 16'h0, 1'b1, 16'h2100, 1'b1, 16'h4100);
            #1;
            check("starve_gnts", 32'({if1.spr_gnt, if1.dma_gnt}), (i == 8 || i == 17) ? 32'b01 : 32'b10);
            check("starve_addr", 32'(if1.mem_addr), (i == 8 || i == 17) ? 32'h4100 : 32'h2100);
            if (i == 9) check("starve_dvalid", 32'({if1.dma_valid, if1.rd_data}), 32'({1'b1, mdata(16'h4100)}));
        end
        idle(4);

        // Reset pulsed one cycle after a sprite grant.
        @(negedge clk_pixel);
        drive(1'b0, 16'h0, 1'b1, 16'h2222, 1'b0, 16'h0);
        #1;
        check("rmid_gnt", 32'(if3.spr_gnt), 32'd1);
        @(negedge clk_pixel);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        reset = 1'b1;
        #1;
        check("rmid_valid1", 32'({if1.vid_valid, if1.spr_valid, if1.dma_valid}), 32'd0);
        check("rmid_stats",  32'({if3.stat_spr_stalls, if3.stat_dma_stalls}), 32'd0);
        @(negedge clk_pixel);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pixel);
            #1;
            check("rmid_no_valid3", 32'({if3.vid_valid, if3.spr_valid, if3.dma_valid, if3.mem_en}), 32'd0);
        end

        // Sprite held off by video for five cycles.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_pixel);
            if (i < 5)       drive(1'b1, 16'(16'h0300 + i), 1'b1, 16'h2300, 1'b0, 16'h0);
            else if (i == 5) drive(1'b0, 16'h0, 1'b1, 16'h2300, 1'b0, 16'h0);
            else             drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
            #1;
            if (i <= 5) check("stall_spr_gnt", 32'(if1.spr_gnt), (i == 5) ? 32'd1 : 32'd0);
        end
        check("stall_svalid", 32'({if1.spr_valid, if1.rd_data}), 32'({1'b1, mdata(16'h2300)}));
        check("stat_spr", 32'(if1.stat_spr_stalls), 32'(EXP_SPR_STALLS));
        check("stat_dma", 32'(if1.stat_dma_stalls), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
